// File: rtl/us_distance_filter.sv
// us_distance_filter
//   Periodically samples the ultrasonic front end's distance/object pair,
//   clamps it, smooths it with a 2**LOG2_N moving average and derives a
//   hysteresis-qualified "obstacle near" flag.
//
//   Optional build macro US_MEDIAN3_EN: inserts a 3-tap median filter in
//   front of the averaging window (one extra cycle of latency, two extra
//   fill ticks, rejects single-sample spikes).
//
// Ports
//   clk_50M   : system clock (single domain)
//   reset     : asynchronous, active-high reset
//   dist_in   : raw distance in mm
//   obj_n     : 0 = echo measured (dist_in valid), 1 = no object
//   dist_avg  : filtered distance in mm
//   avg_valid : one-cycle strobe when dist_avg/near update
//   near      : obstacle-near flag with hysteresis
//   filled    : high once the averaging window holds a full set of samples
module us_distance_filter #(
  parameter int unsigned SAMPLE_CYCLES = 3000000,
  parameter int unsigned LOG2_N        = 2,
  parameter int unsigned MAX_MM        = 4000,
  parameter int unsigned NEAR_MM       = 150,
  parameter int unsigned HYST_MM       = 20
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [15:0] dist_in,
  input  logic        obj_n,
  output logic [15:0] dist_avg,
  output logic        avg_valid,
  output logic        near,
  output logic        filled
);

  localparam int unsigned N      = 1 << LOG2_N;
  localparam int unsigned DW     = 16;
  localparam int unsigned CNT_W  = $clog2(SAMPLE_CYCLES);
  localparam int unsigned SUM_W  = DW + LOG2_N;
`ifdef US_MEDIAN3_EN
  localparam int unsigned FILL_TICKS = N + 2;
`else
  localparam int unsigned FILL_TICKS = N;
`endif
  localparam int unsigned FILL_W = $clog2(FILL_TICKS + 1);

  typedef enum logic {S_FILL, S_RUN} state_t;

  logic [CNT_W-1:0]  presc;
  logic              tick;
  logic [DW-1:0]     samp;
  logic              samp_vld;
  logic [DW-1:0]     win_in;
  logic              win_vld;
  logic [N*DW-1:0]   win;
  logic [DW-1:0]     oldest;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_nxt;
  logic [DW-1:0]     avg_nxt;
  state_t            state;
  state_t            state_nxt;
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_nxt;

  // Sample-period prescaler; tick marks the last count of each period
  assign tick = (presc == CNT_W'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + CNT_W'(1);
  end

  // Sample conditioning: no object and over-range both read as MAX_MM
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      samp     <= '0;
      samp_vld <= 1'b0;
    end else begin
      samp_vld <= tick;
      if (tick) begin
        if (obj_n || (dist_in > DW'(MAX_MM))) samp <= DW'(MAX_MM);
        else                                  samp <= dist_in;
      end
    end
  end

`ifdef US_MEDIAN3_EN
  logic [DW-1:0] med_a;
  logic [DW-1:0] med_b;
  logic [DW-1:0] med_out;
  logic          med_vld;

  function automatic logic [DW-1:0] median3(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
    if ((a >= b && a <= c) || (a <= b && a >= c))      return a;
    else if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
    else                                               return c;
  endfunction

  // Median of the newest conditioned sample and the two before it
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      med_a   <= '0;
      med_b   <= '0;
      med_out <= '0;
      med_vld <= 1'b0;
    end else begin
      med_vld <= samp_vld;
      if (samp_vld) begin
        med_out <= median3(samp, med_a, med_b);
        med_b   <= med_a;
        med_a   <= samp;
      end
    end
  end

  assign win_in  = med_out;
  assign win_vld = med_vld;
`else
  assign win_in  = samp;
  assign win_vld = samp_vld;
`endif

  // Running sum tracks the window contents; entries start at zero so the
  // fill phase subtracts nothing
  assign oldest  = win[N*DW-1 -: DW];
  assign sum_nxt = sum + SUM_W'(win_in) - SUM_W'(oldest);
  assign avg_nxt = DW'(sum_nxt >> LOG2_N);

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      win <= '0;
      sum <= '0;
    end else if (win_vld) begin
      win <= {win[(N-1)*DW-1:0], win_in};
      sum <= sum_nxt;
    end
  end

  // Fill/run state register
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state    <= S_FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  // Next state: leave FILL on the window update that completes the fill
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    case (state)
      S_FILL: begin
        if (win_vld) begin
          fill_nxt = fill_cnt + FILL_W'(1);
          if (fill_nxt == FILL_W'(FILL_TICKS)) state_nxt = S_RUN;
        end
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_FILL;
    endcase
  end

  // Outputs: strobe, average and hysteresis flag update together; the
  // update that completes the fill already produces a strobe
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      dist_avg  <= '0;
      avg_valid <= 1'b0;
      near      <= 1'b0;
      filled    <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      filled    <= (state_nxt == S_RUN);
      if (win_vld && (state_nxt == S_RUN)) begin
        avg_valid <= 1'b1;
        dist_avg  <= avg_nxt;
        if (avg_nxt < DW'(NEAR_MM))                near <= 1'b1;
        else if (avg_nxt > DW'(NEAR_MM + HYST_MM)) near <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_us_distance_filter.sv
// tb_us_distance_filter
//   Self-checking bench for us_distance_filter with SAMPLE_CYCLES=10,
//   LOG2_N=2. Each sample period is driven with junk on non-tick cycles and
//   the intended value on the tick cycle; a sample-history model predicts
//   the strobe, average, near flag and filled flag seen in the next period.
module tb_us_distance_filter;

  localparam int SC   = 10;
  localparam int N    = 4;
  localparam int MAX  = 4000;
  localparam int NEAR = 150;
  localparam int HYST = 20;
`ifdef US_MEDIAN3_EN
  localparam int LAT    = 3;
  localparam int FILL_T = N + 2;
`else
  localparam int LAT    = 2;
  localparam int FILL_T = N;
`endif

  logic        clk_50M;
  logic        reset;
  logic [15:0] dist_in;
  logic        obj_n;
  logic [15:0] dist_avg;
  logic        avg_valid;
  logic        near;
  logic        filled;

  us_distance_filter #(
    .SAMPLE_CYCLES(SC),
    .LOG2_N(2),
    .MAX_MM(MAX),
    .NEAR_MM(NEAR),
    .HYST_MM(HYST)
  ) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .dist_in  (dist_in),
    .obj_n    (obj_n),
    .dist_avg (dist_avg),
    .avg_valid(avg_valid),
    .near     (near),
    .filled   (filled)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: history of window-bound samples since reset
  int   vq[$];
  int   cq[$];
  int   ticks;
  int   m_avg;
  logic m_near;
  logic m_valid;

  // Expected and observed results of one sample period
  int e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled;
  int o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled;

`ifdef US_MEDIAN3_EN
  function automatic int med3(input int a, input int b, input int c);
    int mx, mn;
    mx = a; mn = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (b < mn) mn = b;
    if (c < mn) mn = c;
    return a + b + c - mx - mn;
  endfunction
`endif

  task automatic model_reset();
    vq.delete();
    cq.delete();
    cq.push_back(0);
    cq.push_back(0);
    ticks   = 0;
    m_avg   = 0;
    m_near  = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic model_tick(input int d, input logic o);
    int c, v, s;
    c = o ? MAX : ((d > MAX) ? MAX : d);
`ifdef US_MEDIAN3_EN
    cq.push_back(c);
    v = med3(cq[cq.size()-1], cq[cq.size()-2], cq[cq.size()-3]);
`else
    v = c;
`endif
    vq.push_back(v);
    ticks++;
    m_valid = (ticks >= FILL_T);
    if (m_valid) begin
      s = 0;
      for (int k = 0; k < N; k++) s += vq[vq.size()-1-k];
      m_avg = s / N;
      if (m_avg < NEAR)             m_near = 1'b1;
      else if (m_avg > NEAR + HYST) m_near = 1'b0;
    end
  endtask

  // One sample period: junk inputs except on the tick cycle; records what
  // the DUT shows for the previous tick and what the model predicts for it
  task automatic period(input int d, input logic o);
    e_cnt    = m_valid ? 1 : 0;
    e_pos    = m_valid ? LAT - 1 : 0;
    e_avg    = m_valid ? m_avg : 0;
    e_near   = m_valid ? int'(m_near) : 0;
    e_hold   = m_avg;
    e_hnear  = int'(m_near);
    e_filled = (ticks >= FILL_T) ? 1 : 0;
    o_cnt = 0; o_pos = 0; o_avg = 0; o_near = 0;
    for (int i = 1; i <= SC; i++) begin
      if (i == SC) begin
        dist_in = 16'(d);
        obj_n   = o;
      end else begin
        dist_in = 16'($urandom);
        obj_n   = 1'($urandom);
      end
      @(posedge clk_50M); #1;
      if (avg_valid === 1'b1) begin
        o_cnt++;
        o_pos  = i;
        o_avg  = int'(dist_avg);
        o_near = int'(near);
      end
    end
    o_hold   = int'(dist_avg);
    o_hnear  = int'(near);
    o_filled = int'(filled);
    model_tick(d, o);
  endtask

  task automatic test_reset();
    reset = 1'b1; dist_in = '0; obj_n = 1'b0;
    repeat (2) @(posedge clk_50M);
    #1;
    n_cmp++;
    if ({dist_avg, avg_valid, near, filled} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_state: got avg=%0d valid=%b near=%b filled=%b, want all 0",
               dist_avg, avg_valid, near, filled);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    logic seen;
    seen = 1'b0;
    for (int p = 0; p < FILL_T + 2; p++) begin
      period(200, 1'b0);
      n_cmp++;
      if ({o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled} !==
          {e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled}) begin
        n_bad++;
        $display("FAIL fill[%0d]: got cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d, want cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d",
                 p, o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled,
                 e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled);
      end
      if (o_cnt == 1 && !seen) begin
        seen = 1'b1;
        n_cmp++;
        if (o_avg !== 200 || o_near !== 0 || p !== FILL_T) begin
          n_bad++;
          $display("FAIL first_strobe: got avg=%0d near=%0d period=%0d, want avg=200 near=0 period=%0d",
                   o_avg, o_near, p, FILL_T);
        end
      end
    end
  endtask

  task automatic test_near_hyst();
    int tab_down[5] = '{200, 175, 150, 125, 100};
    int near_down[5] = '{0, 0, 0, 1, 1};
    int tab_up[5] = '{100, 120, 140, 160, 180};
    int near_up[5] = '{1, 1, 1, 1, 0};
    for (int p = 0; p < 10; p++) begin
      period((p < 5) ? 100 : 180, 1'b0);
      n_cmp++;
      if ({o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled} !==
          {e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled}) begin
        n_bad++;
        $display("FAIL hyst[%0d]: got cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d, want cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d",
                 p, o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled,
                 e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled);
      end
`ifndef US_MEDIAN3_EN
      n_cmp++;
      if (p < 5 && (o_avg !== tab_down[p] || o_near !== near_down[p])) begin
        n_bad++;
        $display("FAIL step_down[%0d]: got avg=%0d near=%0d, want avg=%0d near=%0d",
                 p, o_avg, o_near, tab_down[p], near_down[p]);
      end else if (p >= 5 && (o_avg !== tab_up[p-5] || o_near !== near_up[p-5])) begin
        n_bad++;
        $display("FAIL step_up[%0d]: got avg=%0d near=%0d, want avg=%0d near=%0d",
                 p - 5, o_avg, o_near, tab_up[p-5], near_up[p-5]);
      end
`endif
    end
  endtask

  task automatic test_clamp();
    int ds[4] = '{50, 9000, 4000, 4001};
    logic os[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < 6; p++) begin
        period(ds[g], os[g]);
        n_cmp++;
        if ({o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled} !==
            {e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled}) begin
          n_bad++;
          $display("FAIL clamp[%0d.%0d]: got cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d, want cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d",
                   g, p, o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled,
                   e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled);
        end
      end
      n_cmp++;
      if (o_avg !== MAX) begin
        n_bad++;
        $display("FAIL clamp_steady[%0d]: got avg=%0d, want %0d", g, o_avg, MAX);
      end
    end
  endtask

  task automatic test_spike();
    for (int p = 0; p < 12; p++) begin
      period((p == 6) ? 1000 : 200, 1'b0);
      n_cmp++;
      if ({o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled} !==
          {e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled}) begin
        n_bad++;
        $display("FAIL spike[%0d]: got cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d, want cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d",
                 p, o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled,
                 e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled);
      end
`ifdef US_MEDIAN3_EN
      n_cmp++;
      if (p >= 6 && o_avg !== 200) begin
        n_bad++;
        $display("FAIL spike_reject[%0d]: got avg=%0d, want 200", p, o_avg);
      end
`endif
    end
  endtask

  task automatic test_random();
    int d;
    logic o;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 9) == 0) d = int'($urandom_range(3990, 65535));
      else                           d = int'($urandom_range(100, 220));
      o = ($urandom_range(0, 7) == 0);
      period(d, o);
      n_cmp++;
      if ({o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled} !==
          {e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled}) begin
        n_bad++;
        $display("FAIL random[%0d]: got cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d, want cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d",
                 p, o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled,
                 e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int strobes;
    // Asynchronous clear from the running state
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({dist_avg, avg_valid, near, filled} !== 19'd0) begin
      n_bad++;
      $display("FAIL async_reset_run: got avg=%0d valid=%b near=%b filled=%b, want all 0",
               dist_avg, avg_valid, near, filled);
    end
    @(posedge clk_50M); #1;
    reset = 1'b0;
    model_reset();
    period(300, 1'b0);
    period(300, 1'b0);
    repeat (4) @(posedge clk_50M);
    #1;
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({dist_avg, avg_valid, near, filled} !== 19'd0) begin
      n_bad++;
      $display("FAIL async_reset_fill: got avg=%0d valid=%b near=%b filled=%b, want all 0",
               dist_avg, avg_valid, near, filled);
    end
    @(posedge clk_50M); #1;
    reset = 1'b0;
    model_reset();
    strobes = 0;
    for (int p = 0; p <= FILL_T; p++) begin
      period(300, 1'b0);
      n_cmp++;
      if ({o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled} !==
          {e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled}) begin
        n_bad++;
        $display("FAIL refill[%0d]: got cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d, want cnt=%0d pos=%0d avg=%0d near=%0d hold=%0d/%0d filled=%0d",
                 p, o_cnt, o_pos, o_avg, o_near, o_hold, o_hnear, o_filled,
                 e_cnt, e_pos, e_avg, e_near, e_hold, e_hnear, e_filled);
      end
      if (p < FILL_T) strobes += o_cnt;
    end
    n_cmp++;
    if (strobes !== 0 || o_cnt !== 1 || o_avg !== 300) begin
      n_bad++;
      $display("FAIL refill_fresh: got early_strobes=%0d last_cnt=%0d avg=%0d, want 0/1/300",
               strobes, o_cnt, o_avg);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_near_hyst();
    test_clamp();
    test_spike();
    test_random();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/us_distance_filter.md
Name: us_distance_filter

Overview:
- Downstream of the HC-SR04 ultrasonic front end. Consumes its raw distance_out/op pair.
- Samples the pair periodically and smooths it with a power-of-two moving average.
- Produces a filtered distance, a one-cycle update strobe, and a hysteresis-qualified "obstacle near" flag for the motion/control logic.

Parameters:
- SAMPLE_CYCLES, 3000000: clk_50M cycles between samples (60 ms at 50 MHz); must be >= 4.
- LOG2_N, 2: log2 of averaging window depth (N = 4); legal range 1..4.
- MAX_MM, 4000: clamp value; also the substitute when no object is present.
- NEAR_MM, 150: near-flag set threshold in mm (avg strictly below it sets the flag).
- HYST_MM, 20: hysteresis; flag clears when avg is strictly above NEAR_MM+HYST_MM.

Ports:
- clk_50M, input, 1: system clock, 50 MHz. Single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- dist_in, input, 16: raw distance in mm from the ultrasonic stage.
- obj_n, input, 1: object indicator from the ultrasonic stage; 0 = echo measured (dist_in valid), 1 = no object.
- dist_avg, output, 16: filtered distance in mm.
- avg_valid, output, 1: one-cycle pulse when dist_avg/near update.
- near, output, 1: obstacle-near flag, with hysteresis.
- filled, output, 1: high once N samples have been taken since reset.

Behaviour:
- Reset (asynchronous, dominates every other event):
  - dist_avg=0, avg_valid=0, near=0, filled=0.
  - Prescaler, window registers, running sum and fill counter all cleared.
  - Asserting reset mid-operation discards all history; filling restarts from zero.
- Prescaler:
  - Counts 0..SAMPLE_CYCLES-1, then wraps to 0.
  - A sample tick occurs in the cycle where count = SAMPLE_CYCLES-1. First tick is SAMPLE_CYCLES cycles after reset release.
- Sample conditioning, in the tick cycle T (registered):
  - s = MAX_MM if obj_n=1.
  - Otherwise s = min(dist_in, MAX_MM).
- Window and sum:
  - Shift register of N 16-bit entries plus a running sum of width 16+LOG2_N, no overflow possible.
  - At T+1: sum <= sum + s - oldest; s is shifted in and oldest is dropped.
  - Entries are zero after reset, so during fill the subtraction removes 0.
- State machine, states FILL and RUN:
  - FILL: fill counter increments at each T+1. When it reaches N, go to RUN and set filled=1 in that same cycle.
  - RUN: stays in RUN until reset.
  - FILL does not pulse avg_valid.
- Output, at T+2, only when in RUN (including the first cycle after entering RUN):
  - dist_avg = sum >> LOG2_N (truncating divide).
  - avg_valid = 1 for exactly one cycle.
  - Total latency from tick to strobe: 2 cycles.
- Hysteresis, evaluated only on the avg_valid cycle using the new dist_avg:
  - If avg < NEAR_MM, near=1.
  - Else if avg > NEAR_MM+HYST_MM, near=0.
  - Otherwise near holds.
  - near and dist_avg change in the same cycle.
- Between strobes, dist_avg and near hold their values.
- dist_in/obj_n changes outside tick cycles are ignored. Inputs are treated as quasi-static, and the upstream stage is in the same clock domain.
- Wrap-around: prescaler wrap and window shift share the tick cycle; there are no missed or double samples.

Optional Feature:
- Macro: US_MEDIAN3_EN.
- When defined:
  - Conditioned samples pass through a 3-tap median (last three conditioned samples) before the window.
  - Median registers reset to 0.
  - Adds one cycle: tick-to-avg_valid latency becomes 3 cycles.
  - FILL requires N+2 ticks (median pipe primes first).
  - Single-sample spikes are rejected.
- When undefined: no median logic; latency is 2 cycles and FILL takes N ticks.

Test Plan (SAMPLE_CYCLES=10, LOG2_N=2, defaults otherwise, macro undefined unless stated):
- Reset release, obj_n=0, dist_in=200 constant:
  - filled rises after the 4th tick.
  - avg_valid first pulses 2 cycles after the 4th tick with dist_avg=200 and near=0.
  - avg_valid pulses exactly every 10 cycles after that.
- After fill at 200, switch dist_in to 100:
  - Successive dist_avg = 175, 150, 125, 100.
  - near sets on the strobe showing 125.
- From steady 100 with near=1, step dist_in to 180:
  - dist_avg 120, 140, 160 with near held.
  - dist_avg 180 > 170 clears near.
- obj_n=1 with dist_in=50, and separately obj_n=0 with dist_in=9000:
  - Both are sampled as 4000; steady dist_avg=4000.
- Reset asserted mid-FILL after 2 ticks:
  - Outputs go to 0 immediately (asynchronously).
  - After release, 4 fresh ticks are needed before the first avg_valid.
- US_MEDIAN3_EN defined, steady 200 with one tick at 1000:
  - dist_avg stays 200 throughout.
  - First strobe occurs 3 cycles after the 6th tick.
